keypad_scan: RTL and testbench

Matrix-keypad scanner for the lock's input side: drives a 4x4 keypad's columns one at a time, reads the rows, debounces press and release, and emits one single-cycle key event per physical press. It is the input-direction counterpart of the multiplexed seven-segment driver. Key events feed the lock's digit-entry and compare logic, which produces the digits and wrong-attempt count that are shown on the display.

---
 rtl/lock_pkg.sv | 49 ++++
 rtl/scan_tick.sv | 28 ++
 rtl/keypad_scan.sv | 141 ++++++++++++++
 tb/tb_keypad_scan.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the lock's keypad input side.
// Key codes are {row_idx, col_idx} on a standard 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D pad.
package lock_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    localparam logic [3:0] COL_RESET = 4'b1110;

    localparam logic [3:0] KEY_1    = 4'h0;
    localparam logic [3:0] KEY_2    = 4'h1;
    localparam logic [3:0] KEY_3    = 4'h2;
    localparam logic [3:0] KEY_A    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_B    = 4'h7;
    localparam logic [3:0] KEY_7    = 4'h8;
    localparam logic [3:0] KEY_8    = 4'h9;
    localparam logic [3:0] KEY_9    = 4'hA;
    localparam logic [3:0] KEY_C    = 4'hB;
    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_0    = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_D    = 4'hF;

    // True when exactly one line of an active-low 4-bit group is asserted.
    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: one-clk tick every DIV clks, first tick DIV clks after reset.
// No backpressure; tick is a pure function of the count.
module scan_tick #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, debounced press/release, one key_valid per press.
// Latency: key_valid one clk after the DEBOUNCE_CNT-th matching tick; no backpressure on events.
module keypad_scan
    import lock_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    row_m, row_s;
    logic          tick;
    scan_state_t   state, state_n;
    logic [3:0]    col_n, code_n;
    logic [1:0]    row_idx, row_idx_n, col_idx, col_idx_n;
    logic [CW-1:0] db_cnt, db_cnt_n, rel_cnt, rel_cnt_n;
    logic          valid_n;
    logic [3:0]    col_rot, held_rows;

    scan_tick #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m <= ROWS_IDLE;
            row_s <= ROWS_IDLE;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    assign col_rot   = {col[2:0], col[3]};
    // Row pattern expected while the latched key stays the only one down.
    assign held_rows = ~(4'b0001 << row_idx);

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_idx_n = row_idx;
        col_idx_n = col_idx;
        db_cnt_n  = db_cnt;
        rel_cnt_n = rel_cnt;
        code_n    = key_code;
        valid_n   = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low(row_s)) begin
                        row_idx_n = low_idx(row_s);
                        col_idx_n = low_idx(col);
                        db_cnt_n  = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            code_n  = {low_idx(row_s), low_idx(col)};
                            valid_n = 1'b1;
                            state_n = HOLD;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        col_n = col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (row_s == held_rows) begin
                        if (db_cnt == CNT_LAST) begin
                            code_n  = {row_idx, col_idx};
                            valid_n = 1'b1;
                            state_n = HOLD;
                        end
                        db_cnt_n = db_cnt + CW'(1);
                    end else begin
                        col_n   = col_rot;
                        state_n = SCAN;
                    end
                end
                HOLD: begin
                    if (row_s == ROWS_IDLE) begin
                        rel_cnt_n = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            col_n   = col_rot;
                            state_n = SCAN;
                        end else begin
                            state_n = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (row_s == ROWS_IDLE) begin
                        if (rel_cnt == CNT_LAST) begin
                            col_n   = col_rot;
                            state_n = SCAN;
                        end
                        rel_cnt_n = rel_cnt + CW'(1);
                    end else begin
                        state_n = HOLD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col       <= COL_RESET;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            db_cnt    <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row_idx   <= row_idx_n;
            col_idx   <= col_idx_n;
            db_cnt    <= db_cnt_n;
            rel_cnt   <= rel_cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    assign key_down = (state == HOLD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=8, DEBOUNCE_CNT=3 and a passive keypad model.
module tb_keypad_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [3:0][3:0] pressed;   // pressed[r][c]
    int checks;
    int failures;
    int vld_cnt;

    keypad_scan #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row r is pulled low by any pressed key whose column is currently driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r] & ~col);
        end
    end

    always @(posedge clk) begin
        if (key_valid === 1'b1) vld_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int base;
        checks   = 0;
        failures = 0;
        vld_cnt  = 0;
        pressed  = '0;
        rst_n    = 1'b0;

        // Reset and scan rotation
        #22;
        check("rst_col", 32'(col), 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_down", 32'(key_down), 32'h0);
        rst_n = 1'b1;
        step(7);
        check("col_dwell_7", 32'(col), 32'hE);
        step(1);
        check("col_8", 32'(col), 32'hD);
        step(8);
        check("col_16", 32'(col), 32'hB);
        step(16);
        check("col_32", 32'(col), 32'hE);

        // Single press r2,c1 held for 1000 clks
        base = vld_cnt;
        pressed[2][1] = 1'b1;
        step(31);
        check("press_pre_valid", 32'(key_valid), 32'h0);
        check("press_pre_down", 32'(key_down), 32'h0);
        step(1);
        check("press_valid", 32'(key_valid), 32'h1);
        check("press_code", 32'(key_code), 32'h9);
        check("press_down", 32'(key_down), 32'h1);
        step(1);
        check("press_pulse_1clk", 32'(key_valid), 32'h0);
        step(967);
        check("hold_col", 32'(col), 32'hD);
        check("hold_down", 32'(key_down), 32'h1);
        check("hold_one_pulse", 32'(vld_cnt - base), 32'd1);

        // Release bounce: idle one tick, pressed again, then idle for three ticks
        base = vld_cnt;
        pressed[2][1] = 1'b0;
        step(8);
        check("relb_down_a", 32'(key_down), 32'h1);
        pressed[2][1] = 1'b1;
        step(8);
        check("relb_down_b", 32'(key_down), 32'h1);
        pressed[2][1] = 1'b0;
        step(23);
        check("rel_down_before", 32'(key_down), 32'h1);
        step(1);
        check("rel_down_fall", 32'(key_down), 32'h0);
        check("rel_col_next", 32'(col), 32'hB);
        check("rel_no_pulse", 32'(vld_cnt - base), 32'd0);

        // Press bounce: r0,c3 present for a single tick only
        base = vld_cnt;
        step(8);
        check("bounce_col_c3", 32'(col), 32'h7);
        pressed[0][3] = 1'b1;
        step(8);
        check("bounce_col_held", 32'(col), 32'h7);
        check("bounce_down_a", 32'(key_down), 32'h0);
        pressed[0][3] = 1'b0;
        step(8);
        check("bounce_col_resume", 32'(col), 32'hE);
        check("bounce_down_b", 32'(key_down), 32'h0);
        check("bounce_no_pulse", 32'(vld_cnt - base), 32'd0);
        check("code_retained", 32'(key_code), 32'h9);

        // Multi-key in column 0 keeps rotation going
        base = vld_cnt;
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        step(8);
        check("multi_col_1", 32'(col), 32'hD);
        step(24);
        check("multi_col_wrap", 32'(col), 32'hE);
        step(8);
        check("multi_col_again", 32'(col), 32'hD);
        check("multi_down", 32'(key_down), 32'h0);
        check("multi_no_pulse", 32'(vld_cnt - base), 32'd0);
        pressed = '0;

        // Reset after two matching ticks of a debounce on r2,c1
        base = vld_cnt;
        pressed[2][1] = 1'b1;
        step(16);
        check("mid_col_held", 32'(col), 32'hD);
        check("mid_down", 32'(key_down), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", 32'(col), 32'hE);
        check("mid_rst_code", 32'(key_code), 32'h0);
        check("mid_rst_valid", 32'(key_valid), 32'h0);
        check("mid_rst_down", 32'(key_down), 32'h0);
        pressed = '0;
        step(3);
        rst_n = 1'b1;
        step(64);
        check("mid_no_pulse", 32'(vld_cnt - base), 32'd0);
        check("mid_down_after", 32'(key_down), 32'h0);
        check("mid_code_after", 32'(key_code), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
